ui_rom_fetch_arbiter: RTL and testbench

Shares one synchronous UI/character ROM read port between two requesters: the UI timeline reader (single-word fetches) and the character-object reader (bursts of consecutive records).
Round-robin arbitration with valid/ready request handshakes and fixed-latency response strobes.
A stage-reset flush aborts an in-flight burst.
Sits between the UI runtime's ROM readers and the physical ROM in the calculation clock domain.

---
 rtl/ui_rom_pkg.sv | 22 ++
 rtl/ui_rom_fetch_arbiter_if.sv | 37 +++
 rtl/rom_tag_pipe.sv | 44 ++++
 rtl/ui_rom_fetch_arbiter.sv | 133 +++++++++++++
 tb/tb_ui_rom_fetch_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ui_rom_pkg.sv
// Shared types for the UI/character ROM fetch arbiter: owner encoding,
// FSM states and the response tag carried alongside each ROM read.
package ui_rom_pkg;

  typedef enum logic {
    OWNER_UI  = 1'b0,
    OWNER_CHR = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   last;
  } tag_t;

endpackage

// File: rtl/ui_rom_fetch_arbiter_if.sv
// Request/response and ROM-port bundle of the fetch arbiter.
// slave = arbiter side, master = requesters plus ROM side.
interface ui_rom_fetch_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 6
);
  logic                  ui_req_valid;
  logic                  ui_req_ready;
  logic [ADDR_WIDTH-1:0] ui_req_addr;
  logic                  ui_rsp_valid;
  logic [DATA_WIDTH-1:0] ui_rsp_data;
  logic                  chr_req_valid;
  logic                  chr_req_ready;
  logic [ADDR_WIDTH-1:0] chr_req_addr;
  logic [LEN_WIDTH-1:0]  chr_req_len;
  logic                  chr_rsp_valid;
  logic [DATA_WIDTH-1:0] chr_rsp_data;
  logic                  chr_rsp_last;
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport slave (
    input  ui_req_valid, ui_req_addr, chr_req_valid, chr_req_addr, chr_req_len, rom_data,
    output ui_req_ready, ui_rsp_valid, ui_rsp_data,
           chr_req_ready, chr_rsp_valid, chr_rsp_data, chr_rsp_last,
           rom_en, rom_addr
  );

  modport master (
    output ui_req_valid, ui_req_addr, chr_req_valid, chr_req_addr, chr_req_len, rom_data,
    input  ui_req_ready, ui_rsp_valid, ui_rsp_data,
           chr_req_ready, chr_rsp_valid, chr_rsp_data, chr_rsp_last,
           rom_en, rom_addr
  );
endinterface

// File: rtl/rom_tag_pipe.sv
// Tag shift register matching the ROM read latency; the tag leaves the pipe
// in the same cycle its ROM word is presented.
module rom_tag_pipe
  import ui_rom_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic drain_done
);

  tag_t stage_q [LATENCY];
  tag_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = clr ? '0 : tag_in;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = clr ? '0 : stage_q[i-1];
    end
  end

  // Pipe is done once nothing but the exiting stage still holds a valid tag.
  always_comb begin
    drain_done = 1'b1;
    for (int i = 0; i < LATENCY - 1; i++) begin
      if (stage_q[i].valid) drain_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign tag_out = stage_q[LATENCY-1];

endmodule

// File: rtl/ui_rom_fetch_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port between the UI
// timeline reader (single words) and the character reader (bursts).
module ui_rom_fetch_arbiter
  import ui_rom_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 64,
  parameter int LEN_WIDTH   = 6,
  parameter int ROM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  ui_rom_fetch_arbiter_if.slave  bus,
  output logic                   busy
);

  state_e                state_q, state_d;
  owner_e                last_grant_q, last_grant_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [DATA_WIDTH-1:0] ui_data_q, ui_data_d;
  logic [DATA_WIDTH-1:0] chr_data_q, chr_data_d;

  tag_t tag_in, tag_out;
  logic drain_done;
  logic can_accept, grant_ui, grant_chr, accept_ui, accept_chr, accept_issue;
  logic last_beat, ui_strobe, chr_strobe;

  // Reset gates ready so nothing looks accepted while the block is held.
  always_comb begin
    can_accept   = (state_q == ST_IDLE) && !flush && !reset;
    grant_chr    = bus.chr_req_valid && (!bus.ui_req_valid || (last_grant_q == OWNER_UI));
    grant_ui     = bus.ui_req_valid && !grant_chr;
    accept_ui    = can_accept && grant_ui;
    accept_chr   = can_accept && grant_chr;
    accept_issue = accept_ui || (accept_chr && (bus.chr_req_len != '0));
    last_beat    = (beat_q == (len_q - LEN_WIDTH'(1)));
    ui_strobe    = tag_out.valid && (tag_out.owner == OWNER_UI) && !flush;
    chr_strobe   = tag_out.valid && (tag_out.owner == OWNER_CHR) && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_issue) state_d = ST_ISSUE;
      ST_ISSUE: if (last_beat)    state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    bus.ui_req_ready  = accept_ui;
    bus.chr_req_ready = accept_chr;
    bus.rom_en        = (state_q == ST_ISSUE);
    bus.rom_addr      = (state_q == ST_ISSUE) ? base_q + ADDR_WIDTH'(beat_q) : '0;
    busy              = (state_q != ST_IDLE);
    bus.ui_rsp_valid  = ui_strobe;
    bus.ui_rsp_data   = ui_strobe ? bus.rom_data : ui_data_q;
    bus.chr_rsp_valid = chr_strobe;
    bus.chr_rsp_data  = chr_strobe ? bus.rom_data : chr_data_q;
    bus.chr_rsp_last  = chr_strobe && tag_out.last;
  end

  always_comb begin
    base_d       = base_q;
    len_d        = len_q;
    beat_d       = beat_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ui_data_d    = ui_data_q;
    chr_data_d   = chr_data_q;
    if (accept_ui) begin
      base_d       = bus.ui_req_addr;
      len_d        = LEN_WIDTH'(1);
      beat_d       = '0;
      owner_d      = OWNER_UI;
      last_grant_d = OWNER_UI;
    end else if (accept_chr) begin
      base_d       = bus.chr_req_addr;
      len_d        = bus.chr_req_len;
      beat_d       = '0;
      owner_d      = OWNER_CHR;
      last_grant_d = OWNER_CHR;
    end else if (state_q == ST_ISSUE) begin
      beat_d = beat_q + LEN_WIDTH'(1);
    end
    if (ui_strobe)  ui_data_d  = bus.rom_data;
    if (chr_strobe) chr_data_d = bus.rom_data;
    tag_in.valid = (state_q == ST_ISSUE);
    tag_in.owner = owner_q;
    tag_in.last  = last_beat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= OWNER_CHR;
      owner_q      <= OWNER_UI;
      base_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      ui_data_q    <= '0;
      chr_data_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      ui_data_q    <= ui_data_d;
      chr_data_q   <= chr_data_d;
    end
  end

  rom_tag_pipe #(.LATENCY(ROM_LATENCY)) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .clr        (flush),
    .tag_in     (tag_in),
    .tag_out    (tag_out),
    .drain_done (drain_done)
  );

endmodule

// File: tb/tb_ui_rom_fetch_arbiter.sv
// Directed bench for ui_rom_fetch_arbiter with a two-cycle synchronous ROM model.
module tb_ui_rom_fetch_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int LW  = 6;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  ui_rom_fetch_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ui_rom_fetch_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ROM_LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {16'hBEEF, 6'd0, a, 16'h1234, 6'd0, ~a};
  endfunction

  // ROM: word for the address presented in cycle N appears in cycle N+2.
  logic [DW-1:0] rom_p1, rom_p2;
  always @(posedge clk) begin
    rom_p1 <= rom_word(bus.rom_addr);
    rom_p2 <= rom_p1;
  end
  assign bus.rom_data = rom_p2;

  task automatic idle_inputs();
    bus.ui_req_valid  = 1'b0;
    bus.ui_req_addr   = '0;
    bus.chr_req_valid = 1'b0;
    bus.chr_req_addr  = '0;
    bus.chr_req_len   = '0;
    flush             = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    checks++;
    if ({bus.ui_req_ready, bus.chr_req_ready, bus.ui_rsp_valid, bus.chr_rsp_valid,
         bus.chr_rsp_last, bus.rom_en, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.ui_req_ready, bus.chr_req_ready,
               bus.ui_rsp_valid, bus.chr_rsp_valid, bus.chr_rsp_last, bus.rom_en, busy});
    end
    checks++;
    if ({bus.ui_rsp_data, bus.chr_rsp_data, bus.rom_addr} !== '0) begin
      failures++;
      $display("FAIL reset_data ui=%h chr=%h addr=%h exp=0", bus.ui_rsp_data, bus.chr_rsp_data, bus.rom_addr);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ui_only();
    @(negedge clk);
    bus.ui_req_valid = 1'b1;
    bus.ui_req_addr  = 10'h005;
    #1;
    checks++;
    if (bus.ui_req_ready !== 1'b1) begin
      failures++; $display("FAIL ui_accept got=%b exp=1", bus.ui_req_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.ui_req_valid = 1'b0;
      bus.ui_req_addr  = 10'h3AA;
      #1;
      checks++;
      if (bus.rom_en !== (k == 1) || bus.rom_addr !== ((k == 1) ? 10'h005 : 10'h000)) begin
        failures++;
        $display("FAIL ui_rom k=%0d got en=%b addr=%h exp en=%b addr=%h", k, bus.rom_en, bus.rom_addr,
                 (k == 1), ((k == 1) ? 10'h005 : 10'h000));
      end
      checks++;
      if (bus.ui_rsp_valid !== (k == 3)) begin
        failures++; $display("FAIL ui_rsp_valid k=%0d got=%b exp=%b", k, bus.ui_rsp_valid, (k == 3));
      end
      checks++;
      if (busy !== (k <= 3)) begin
        failures++; $display("FAIL ui_busy k=%0d got=%b exp=%b", k, busy, (k <= 3));
      end
      if (k >= 3) begin
        checks++;
        if (bus.ui_rsp_data !== rom_word(10'h005)) begin
          failures++; $display("FAIL ui_rsp_data k=%0d got=%h exp=%h", k, bus.ui_rsp_data, rom_word(10'h005));
        end
      end
    end
  endtask

  task automatic test_chr_burst();
    @(negedge clk);
    bus.chr_req_valid = 1'b1;
    bus.chr_req_addr  = 10'h010;
    bus.chr_req_len   = 6'd4;
    #1;
    checks++;
    if (bus.chr_req_ready !== 1'b1 || bus.ui_req_ready !== 1'b0) begin
      failures++; $display("FAIL chr_accept got=%b ui=%b exp=1/0", bus.chr_req_ready, bus.ui_req_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      logic [AW-1:0] ea, ed;
      @(negedge clk);
      bus.chr_req_valid = 1'b0;
      bus.chr_req_addr  = 10'h2FF;
      bus.chr_req_len   = 6'd9;
      #1;
      ea = 10'h010 + AW'(k - 1);
      ed = 10'h010 + AW'(k - 3);
      checks++;
      if (bus.rom_en !== (k <= 4) || (k <= 4 && bus.rom_addr !== ea)) begin
        failures++; $display("FAIL chr_rom k=%0d got en=%b addr=%h exp en=%b addr=%h", k, bus.rom_en, bus.rom_addr, (k <= 4), ea);
      end
      checks++;
      if (bus.chr_rsp_valid !== (k >= 3 && k <= 6) || bus.chr_rsp_last !== (k == 6)) begin
        failures++; $display("FAIL chr_strobe k=%0d got v=%b l=%b exp v=%b l=%b", k, bus.chr_rsp_valid,
                             bus.chr_rsp_last, (k >= 3 && k <= 6), (k == 6));
      end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (bus.chr_rsp_data !== rom_word(ed)) begin
          failures++; $display("FAIL chr_data k=%0d got=%h exp=%h", k, bus.chr_rsp_data, rom_word(ed));
        end
      end
      checks++;
      if (busy !== (k <= 6)) begin
        failures++; $display("FAIL chr_busy k=%0d got=%b exp=%b", k, busy, (k <= 6));
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.chr_req_valid = 1'b1;
    bus.chr_req_addr  = 10'h3FE;
    bus.chr_req_len   = 6'd4;
    for (int k = 1; k <= 7; k++) begin
      logic [AW-1:0] ea, ed;
      @(negedge clk);
      bus.chr_req_valid = 1'b0;
      #1;
      ea = 10'h3FE + AW'(k - 1);
      ed = 10'h3FE + AW'(k - 3);
      if (k <= 4) begin
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== ea) begin
          failures++; $display("FAIL wrap_addr k=%0d got en=%b addr=%h exp addr=%h", k, bus.rom_en, bus.rom_addr, ea);
        end
      end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (bus.chr_rsp_valid !== 1'b1 || bus.chr_rsp_data !== rom_word(ed)) begin
          failures++; $display("FAIL wrap_data k=%0d got v=%b d=%h exp=%h", k, bus.chr_rsp_valid, bus.chr_rsp_data, rom_word(ed));
        end
      end
    end
  endtask

  task automatic test_contention();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    bus.ui_req_valid  = 1'b1;
    bus.ui_req_addr   = 10'h020;
    bus.chr_req_valid = 1'b1;
    bus.chr_req_addr  = 10'h040;
    bus.chr_req_len   = 6'd1;
    for (int r = 0; r < 6; r++) begin
      for (int off = 0; off < 4; off++) begin
        logic eu, ec;
        if (r != 0 || off != 0) @(negedge clk);
        #1;
        eu = (off == 0) && (r % 2 == 0);
        ec = (off == 0) && (r % 2 == 1);
        checks++;
        if (bus.ui_req_ready !== eu || bus.chr_req_ready !== ec) begin
          failures++; $display("FAIL rr_grant r=%0d off=%0d got ui=%b chr=%b exp ui=%b chr=%b", r, off,
                               bus.ui_req_ready, bus.chr_req_ready, eu, ec);
        end
        if (off == 3) begin
          checks++;
          if (bus.ui_rsp_valid !== (r % 2 == 0) || bus.chr_rsp_valid !== (r % 2 == 1)
              || bus.chr_rsp_last !== (r % 2 == 1)) begin
            failures++; $display("FAIL rr_rsp r=%0d got ui=%b chr=%b last=%b", r, bus.ui_rsp_valid,
                                 bus.chr_rsp_valid, bus.chr_rsp_last);
          end
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.chr_req_valid = 1'b1;
    bus.chr_req_addr  = 10'h100;
    bus.chr_req_len   = 6'd10;
    #1;
    checks++;
    if (bus.chr_req_ready !== 1'b1) begin
      failures++; $display("FAIL flush_accept got=%b exp=1", bus.chr_req_ready);
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.chr_req_valid = 1'b0;
      bus.ui_req_valid  = (k <= 5);
      bus.ui_req_addr   = 10'h0AB;
      flush             = (k == 4);
      #1;
      if (k <= 3) begin
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 10'h100 + AW'(k - 1) || bus.ui_req_ready !== 1'b0) begin
          failures++; $display("FAIL flush_issue k=%0d got en=%b addr=%h rdy=%b", k, bus.rom_en, bus.rom_addr, bus.ui_req_ready);
        end
      end
      if (k == 3) begin
        checks++;
        if (bus.chr_rsp_valid !== 1'b1 || bus.chr_rsp_data !== rom_word(10'h100)) begin
          failures++; $display("FAIL flush_beat0 got v=%b d=%h exp=%h", bus.chr_rsp_valid, bus.chr_rsp_data, rom_word(10'h100));
        end
      end
      if (k >= 4) begin
        checks++;
        if (bus.chr_rsp_valid !== 1'b0) begin
          failures++; $display("FAIL flush_no_strobe k=%0d got=%b exp=0", k, bus.chr_rsp_valid);
        end
      end
      if (k == 4) begin
        checks++;
        if (bus.ui_req_ready !== 1'b0) begin
          failures++; $display("FAIL flush_cycle_ready got=%b exp=0", bus.ui_req_ready);
        end
      end
      if (k == 5) begin
        checks++;
        if (busy !== 1'b0 || bus.rom_en !== 1'b0 || bus.ui_req_ready !== 1'b1) begin
          failures++; $display("FAIL flush_after got busy=%b en=%b rdy=%b exp 0/0/1", busy, bus.rom_en, bus.ui_req_ready);
        end
      end
      if (k == 6) begin
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 10'h0AB || bus.chr_rsp_data !== rom_word(10'h100)) begin
          failures++; $display("FAIL flush_ui_issue got en=%b addr=%h chr=%h", bus.rom_en, bus.rom_addr, bus.chr_rsp_data);
        end
      end
      if (k == 8) begin
        checks++;
        if (bus.ui_rsp_valid !== 1'b1 || bus.ui_rsp_data !== rom_word(10'h0AB)) begin
          failures++; $display("FAIL flush_ui_rsp got v=%b d=%h exp=%h", bus.ui_rsp_valid, bus.ui_rsp_data, rom_word(10'h0AB));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_len0();
    @(negedge clk);
    bus.chr_req_valid = 1'b1;
    bus.chr_req_addr  = 10'h050;
    bus.chr_req_len   = 6'd0;
    #1;
    checks++;
    if (bus.chr_req_ready !== 1'b1) begin
      failures++; $display("FAIL len0_accept got=%b exp=1", bus.chr_req_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.chr_req_valid = (k == 1);
      bus.chr_req_len   = 6'd3;
      bus.ui_req_valid  = (k == 1);
      bus.ui_req_addr   = 10'h060;
      #1;
      if (k == 1) begin
        checks++;
        if (bus.ui_req_ready !== 1'b1 || bus.chr_req_ready !== 1'b0 || bus.rom_en !== 1'b0 || busy !== 1'b0) begin
          failures++; $display("FAIL len0_next got ui=%b chr=%b en=%b busy=%b exp 1/0/0/0",
                               bus.ui_req_ready, bus.chr_req_ready, bus.rom_en, busy);
        end
      end
      if (k == 2) begin
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 10'h060) begin
          failures++; $display("FAIL len0_ui_addr got en=%b addr=%h exp 1/060", bus.rom_en, bus.rom_addr);
        end
      end
      checks++;
      if (bus.chr_rsp_valid !== 1'b0 || bus.ui_rsp_valid !== (k == 4)) begin
        failures++; $display("FAIL len0_rsp k=%0d got chr=%b ui=%b", k, bus.chr_rsp_valid, bus.ui_rsp_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.chr_req_valid = 1'b1;
    bus.chr_req_addr  = 10'h200;
    bus.chr_req_len   = 6'd8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.chr_req_valid = 1'b0;
      #1;
    end
    checks++;
    if (bus.chr_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL areset_pre got=%b exp=1", bus.chr_rsp_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.rom_en, busy, bus.chr_rsp_valid, bus.chr_rsp_last, bus.ui_req_ready, bus.chr_req_ready} !== 6'b0
        || bus.rom_addr !== '0 || bus.chr_rsp_data !== '0 || bus.ui_rsp_data !== '0) begin
      failures++; $display("FAIL areset_immediate got en=%b busy=%b v=%b addr=%h d=%h exp 0",
                           bus.rom_en, busy, bus.chr_rsp_valid, bus.rom_addr, bus.chr_rsp_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.chr_rsp_valid !== 1'b0 || bus.rom_en !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL areset_after k=%0d got v=%b en=%b busy=%b exp 0", k, bus.chr_rsp_valid, bus.rom_en, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ui_only();
    test_chr_burst();
    test_wrap();
    test_contention();
    test_flush();
    test_len0();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
